// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, FSM encoding and latency helper for the issue-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int NUM_REGS      = 16;
  localparam int IDX_W         = 4;
  localparam int ALU_LAT       = 1;
  localparam int MEM_LAT       = 3;
  localparam int CNT_W         = 2;
  localparam int FLUSH_BUBBLES = 2;
  localparam int FLUSH_W       = 2;
  localparam int STALL_CNT_W   = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] write_latency(input logic is_load);
    return is_load ? CNT_W'(MEM_LAT) : CNT_W'(ALU_LAT);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute-side bundle: instruction fields and branch in, issue control out.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic             id_valid;
  logic [IDX_W-1:0] id_src0;
  logic [IDX_W-1:0] id_src1;
  logic             id_use0;
  logic             id_use1;
  logic [IDX_W-1:0] id_dst;
  logic             id_wr_en;
  logic             id_is_load;
  logic             br_taken;
  logic             issue_o;
  logic             stall_o;
  logic             flush_o;
  logic             fw_sel0;
  logic             fw_sel1;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_src0, id_src1, id_use0, id_use1, id_dst, id_wr_en, id_is_load, br_taken,
    input  issue_o, stall_o, flush_o, fw_sel0, fw_sel1, stall_cnt
  );

  modport slave (
    input  id_valid, id_src0, id_src1, id_use0, id_use1, id_dst, id_wr_en, id_is_load, br_taken,
    output issue_o, stall_o, flush_o, fw_sel0, fw_sel1, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_sb_counter_bank.sv
// Per-register result countdowns; a new write reloads its entry, all others decay toward zero.
module sb_counter_bank
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [CNT_W-1:0] load_val,
  input  logic [IDX_W-1:0] rd_idx0,
  input  logic [IDX_W-1:0] rd_idx1,
  input  logic [IDX_W-1:0] dst_idx,
  output logic [CNT_W-1:0] rd_cnt0,
  output logic [CNT_W-1:0] rd_cnt1,
  output logic [CNT_W-1:0] dst_cnt
);

  logic [CNT_W-1:0] cnt [NUM_REGS];

  // The reload of a freshly issued write takes precedence over the decay of the old value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_en && load_idx == IDX_W'(i)) cnt[i] <= load_val;
        else if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign rd_cnt0 = cnt[rd_idx0];
  assign rd_cnt1 = cnt[rd_idx1];
  assign dst_cnt = cnt[dst_idx];

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage controller: RAW/WAW stall detection, forward-select, branch flush and stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  hazard_scoreboard_if.slave bus
);

  state_t                 state_q, state_d;
  logic [FLUSH_W-1:0]     flush_q, flush_d;
  logic [STALL_CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0]       cnt0, cnt1, cnt_dst, new_lat;
  logic                   haz0, haz1, waw, hazard;
  logic                   issue_raw, stall_raw, flush_raw;
  logic                   issue, stall;

  assign new_lat = write_latency(bus.id_is_load);

  sb_counter_bank u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_en  (issue & bus.id_wr_en),
    .load_idx (bus.id_dst),
    .load_val (new_lat),
    .rd_idx0  (bus.id_src0),
    .rd_idx1  (bus.id_src1),
    .dst_idx  (bus.id_dst),
    .rd_cnt0  (cnt0),
    .rd_cnt1  (cnt1),
    .dst_cnt  (cnt_dst)
  );

  assign haz0   = bus.id_use0 & (cnt0 > CNT_W'(1));
  assign haz1   = bus.id_use1 & (cnt1 > CNT_W'(1));
  assign waw    = bus.id_wr_en & (cnt_dst > new_lat);
  assign hazard = bus.id_valid & (haz0 | haz1 | waw);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // A taken branch overrides whatever the current state would do and restarts the bubble count
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    issue_raw = 1'b0;
    stall_raw = 1'b0;
    flush_raw = 1'b0;
    case (state_q)
      RUN: begin
        issue_raw = bus.id_valid & ~hazard;
        stall_raw = hazard;
      end
      FLUSH: begin
        flush_raw = 1'b1;
        if (flush_q <= FLUSH_W'(1)) begin
          state_d = RUN;
          flush_d = '0;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (bus.br_taken) begin
      issue_raw = 1'b0;
      stall_raw = 1'b0;
      flush_raw = 1'b1;
      state_d   = FLUSH;
      flush_d   = FLUSH_W'(FLUSH_BUBBLES);
    end
  end

  // Outputs are forced low while reset is held, independent of the decode inputs
  assign issue       = issue_raw & reset_n;
  assign stall       = stall_raw & reset_n;
  assign bus.issue_o = issue;
  assign bus.stall_o = stall;
  assign bus.flush_o = flush_raw & reset_n;
  assign bus.fw_sel0 = reset_n & bus.id_use0 & (cnt0 == CNT_W'(1));
  assign bus.fw_sel1 = reset_n & bus.id_use1 & (cnt1 == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_count_q <= '0;
    else if (stall && stall_count_q != '1) stall_count_q <= stall_count_q + 1'b1;
  end

  assign bus.stall_cnt = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with immediate-assertion checks.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic reset_n;
  int   pass_count;
  int   check_count;

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic valid, input logic [3:0] src0, input logic use0,
                                input logic [3:0] src1, input logic use1, input logic [3:0] dst,
                                input logic wr_en, input logic is_load, input logic br);
    bus.id_valid   = valid;
    bus.id_src0    = src0;
    bus.id_use0    = use0;
    bus.id_src1    = src1;
    bus.id_use1    = use1;
    bus.id_dst     = dst;
    bus.id_wr_en   = wr_en;
    bus.id_is_load = is_load;
    bus.br_taken   = br;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic issue, input logic stall,
                            input logic flush, input logic fw0, input logic fw1);
    @(negedge clk);
    check_output({tag, ".issue"}, 16'(bus.issue_o), 16'(issue));
    check_output({tag, ".stall"}, 16'(bus.stall_o), 16'(stall));
    check_output({tag, ".flush"}, 16'(bus.flush_o), 16'(flush));
    check_output({tag, ".fw0"},   16'(bus.fw_sel0), 16'(fw0));
    check_output({tag, ".fw1"},   16'(bus.fw_sel1), 16'(fw1));
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    reset_n     = 1'b0;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #12;
    $display("[TB] reset state");
    check_output("rst.issue", 16'(bus.issue_o), 16'd0);
    check_output("rst.flush", 16'(bus.flush_o), 16'd0);
    check_output("rst.stall_cnt", bus.stall_cnt, 16'd0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    $display("[TB] ALU forward");
    apply_stimulus(1, 1, 1, 2, 1, 3, 1, 0, 0);
    check_ctrl("add_r3", 1, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 3, 1, 0, 0, 9, 0, 0, 0);
    check_ctrl("use_r3_fwd", 1, 0, 0, 1, 0);
    next_cycle();
    check_ctrl("use_r3_rf", 1, 0, 0, 0, 0);
    next_cycle();

    $display("[TB] load-use stall");
    apply_stimulus(1, 0, 0, 0, 0, 5, 1, 1, 0);
    check_ctrl("load_r5", 1, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 5, 1, 0, 0, 6, 1, 0, 0);
    check_ctrl("use_r5_s1", 0, 1, 0, 0, 0);
    next_cycle();
    check_ctrl("use_r5_s2", 0, 1, 0, 0, 0);
    next_cycle();
    check_ctrl("use_r5_go", 1, 0, 0, 1, 0);
    check_output("stall_cnt_2", bus.stall_cnt, 16'd2);
    next_cycle();

    $display("[TB] WAW");
    apply_stimulus(1, 0, 0, 0, 0, 4, 1, 1, 0);
    check_ctrl("load_r4", 1, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
    check_ctrl("waw_s1", 0, 1, 0, 0, 0);
    next_cycle();
    check_ctrl("waw_s2", 0, 1, 0, 0, 0);
    next_cycle();
    check_ctrl("waw_go", 1, 0, 0, 0, 0);
    check_output("stall_cnt_4", bus.stall_cnt, 16'd4);
    next_cycle();
    apply_stimulus(1, 4, 0, 4, 1, 0, 0, 0, 0);
    check_ctrl("waw_reload", 1, 0, 0, 0, 1);
    next_cycle();

    $display("[TB] branch flush");
    apply_stimulus(1, 0, 0, 0, 0, 8, 1, 1, 0);
    check_ctrl("load_r8", 1, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 9, 1, 0, 1);
    check_ctrl("br_pulse", 0, 0, 1, 0, 0);
    next_cycle();
    apply_stimulus(1, 8, 1, 9, 1, 10, 1, 0, 0);
    check_ctrl("flush_1", 0, 0, 1, 0, 0);
    next_cycle();
    apply_stimulus(1, 8, 1, 0, 0, 10, 1, 0, 0);
    check_ctrl("flush_2", 0, 0, 1, 1, 0);
    next_cycle();
    check_ctrl("after_flush", 1, 0, 0, 0, 0);
    next_cycle();

    $display("[TB] async reset mid-stall");
    apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1, 0);
    check_ctrl("load_r7", 1, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 7, 1, 0, 0, 11, 1, 0, 0);
    check_ctrl("use_r7_s1", 0, 1, 0, 0, 0);
    next_cycle();
    check_ctrl("use_r7_s2", 0, 1, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    check_output("midrst.stall", 16'(bus.stall_o), 16'd0);
    check_output("midrst.issue", 16'(bus.issue_o), 16'd0);
    check_output("midrst.stall_cnt", bus.stall_cnt, 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    check_ctrl("use_r7_post", 1, 0, 0, 0, 0);
    next_cycle();

    $display("[TB] stall counter saturation");
    apply_stimulus(1, 12, 1, 0, 0, 12, 1, 1, 0);
    check_ctrl("sat_c1", 1, 0, 0, 0, 0);
    next_cycle();
    check_ctrl("sat_c2", 0, 1, 0, 0, 0);
    force dut.stall_count_q = 16'hFFFD;
    #1 release dut.stall_count_q;
    next_cycle();
    check_ctrl("sat_c3", 0, 1, 0, 0, 0);
    check_output("sat_fffe", bus.stall_cnt, 16'hFFFE);
    next_cycle();
    check_ctrl("sat_c4", 1, 0, 0, 1, 0);
    check_output("sat_ffff_a", bus.stall_cnt, 16'hFFFF);
    next_cycle();
    check_ctrl("sat_c5", 0, 1, 0, 0, 0);
    next_cycle();
    check_ctrl("sat_c6", 0, 1, 0, 0, 0);
    check_output("sat_ffff_b", bus.stall_cnt, 16'hFFFF);
    next_cycle();
    check_output("sat_ffff_c", bus.stall_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
